// File: rtl/dprintf_4_arbiter_if.sv
// rtl/dprintf_4_arbiter_if.sv - requester/downstream signal bundle for dprintf_4_arbiter
// master drives requests and ack_out; slave is the arbiter.
interface dprintf_4_arbiter_if #(
  parameter int ID_W = 2
);
  localparam int NUM_REQ = 2 ** ID_W;

  logic [NUM_REQ-1:0]    req_in__valid;
  logic [16*NUM_REQ-1:0] req_in__address;
  logic [64*NUM_REQ-1:0] req_in__data_0;
  logic [64*NUM_REQ-1:0] req_in__data_1;
  logic [64*NUM_REQ-1:0] req_in__data_2;
  logic [64*NUM_REQ-1:0] req_in__data_3;
  logic [NUM_REQ-1:0]    req_in__ack;
  logic                  req_out__valid;
  logic [15:0]           req_out__address;
  logic [63:0]           req_out__data_0;
  logic [63:0]           req_out__data_1;
  logic [63:0]           req_out__data_2;
  logic [63:0]           req_out__data_3;
  logic                  ack_out;
  logic [ID_W-1:0]       grant_id;
  logic                  busy;

  modport master (
    output req_in__valid, req_in__address,
    output req_in__data_0, req_in__data_1, req_in__data_2, req_in__data_3,
    output ack_out,
    input  req_in__ack, req_out__valid, req_out__address,
    input  req_out__data_0, req_out__data_1, req_out__data_2, req_out__data_3,
    input  grant_id, busy
  );

  modport slave (
    input  req_in__valid, req_in__address,
    input  req_in__data_0, req_in__data_1, req_in__data_2, req_in__data_3,
    input  ack_out,
    output req_in__ack, req_out__valid, req_out__address,
    output req_out__data_0, req_out__data_1, req_out__data_2, req_out__data_3,
    output grant_id, busy
  );
endinterface

// File: rtl/dprintf_4_arbiter.sv
// rtl/dprintf_4_arbiter.sv - round-robin arbiter sharing one dprintf_4 request channel
// Define DPRINTF_ARB_PIPELINE_EN to capture the next winner on the ack_out edge (zero bubble).
module dprintf_4_arbiter #(
  parameter int ID_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  dprintf_4_arbiter_if.slave bus
);
  localparam int NUM_REQ = 2 ** ID_W;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [15:0]        addr_q, addr_d;
  logic [63:0]        data0_q, data0_d;
  logic [63:0]        data1_q, data1_d;
  logic [63:0]        data2_q, data2_d;
  logic [63:0]        data3_q, data3_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    cand;
  logic               capture;

  // A requester acked this cycle still shows valid; masking it prevents a double grant.
  always_comb begin
    eligible  = bus.req_in__valid & ~ack_q;
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last_grant_q + ID_W'(k);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ack_d        = '0;
    addr_d       = addr_q;
    data0_d      = data0_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    data3_d      = data3_q;
    capture      = 1'b0;
    case (state_q)
      IDLE: capture = win_found;
      ISSUE: begin
        if (bus.ack_out) begin
`ifdef DPRINTF_ARB_PIPELINE_EN
          capture = win_found;
`else
          capture = 1'b0;
`endif
          if (!capture) state_d = IDLE;
        end
      end
    endcase
    if (capture) begin
      state_d      = ISSUE;
      last_grant_d = win_id;
      grant_id_d   = win_id;
      ack_d        = NUM_REQ'(1) << win_id;
      addr_d       = bus.req_in__address[16*win_id +: 16];
      data0_d      = bus.req_in__data_0[64*win_id +: 64];
      data1_d      = bus.req_in__data_1[64*win_id +: 64];
      data2_d      = bus.req_in__data_2[64*win_id +: 64];
      data3_d      = bus.req_in__data_3[64*win_id +: 64];
    end
  end

  // last_grant resets to NUM_REQ-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= '1;
      grant_id_q   <= '0;
      ack_q        <= '0;
      addr_q       <= '0;
      data0_q      <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      data3_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ack_q        <= ack_d;
      addr_q       <= addr_d;
      data0_q      <= data0_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      data3_q      <= data3_d;
    end
  end

  assign bus.req_in__ack      = ack_q;
  assign bus.req_out__valid   = (state_q == ISSUE);
  assign bus.busy             = (state_q == ISSUE);
  assign bus.req_out__address = addr_q;
  assign bus.req_out__data_0  = data0_q;
  assign bus.req_out__data_1  = data1_q;
  assign bus.req_out__data_2  = data2_q;
  assign bus.req_out__data_3  = data3_q;
  assign bus.grant_id         = grant_id_q;
endmodule

// File: tb/tb_dprintf_4_arbiter.sv
// tb/tb_dprintf_4_arbiter.sv - scoreboard bench for dprintf_4_arbiter
// Reference model predicts each capture from round-robin rules; a negedge monitor checks outputs.
module tb_dprintf_4_arbiter;
  localparam int ID_W = 2;
  localparam int N    = 4;
`ifdef DPRINTF_ARB_PIPELINE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [15:0]     addr;
    logic [255:0]    data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dprintf_4_arbiter_if #(.ID_W(ID_W)) bus ();
  dprintf_4_arbiter #(.ID_W(ID_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  exp_t         sb[$];
  int           seen_ids[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] v, renew, keep;
  logic [15:0]  a[N];
  logic [255:0] d[N];
  logic         ack_o, rst_i;
  bit           rand_mode, flush, mon_en, m_valid, exp_valid_cur;
  int           m_last;
  logic [N-1:0] exp_ack_cur, exp_ack_next;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic new_payload(input int i);
    v[i] = 1'b1;
    a[i] = 16'($urandom);
    d[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Start of a cycle: advance expectations, let requesters react to this cycle's ack.
  task automatic begin_cycle();
    @(posedge clk);
    #1;
    if (flush) begin
      sb.delete();
      flush = 1'b0;
    end
    exp_ack_cur   = exp_ack_next;
    exp_valid_cur = m_valid;
    for (int i = 0; i < N; i++) begin
      if (exp_ack_cur[i] && v[i]) begin
        if (renew[i] || (rand_mode && $urandom_range(1, 0) == 1)) new_payload(i);
        else if (!keep[i]) v[i] = 1'b0;
      end
    end
    if (rand_mode) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(3, 0) == 0) new_payload(i);
      ack_o = ($urandom_range(2, 0) != 0);
    end
  endtask

  // End of stimulus for a cycle: drive pins, then predict what the coming edge does.
  task automatic end_cycle();
    bit   hs, free;
    int   win;
    exp_t e;
    reset       = rst_i;
    bus.ack_out = ack_o;
    for (int i = 0; i < N; i++) begin
      bus.req_in__valid[i]             = v[i];
      bus.req_in__address[16*i +: 16]  = a[i];
      bus.req_in__data_0[64*i +: 64]   = d[i][63:0];
      bus.req_in__data_1[64*i +: 64]   = d[i][127:64];
      bus.req_in__data_2[64*i +: 64]   = d[i][191:128];
      bus.req_in__data_3[64*i +: 64]   = d[i][255:192];
    end
    exp_ack_next = '0;
    if (rst_i) begin
      m_valid = 1'b0;
      m_last  = N - 1;
      flush   = 1'b1;
    end else begin
      hs   = m_valid && ack_o;
      free = !m_valid || (PIPE && hs);
      win  = -1;
      if (free)
        for (int k = 1; k <= N; k++)
          if (win < 0 && v[(m_last + k) % N] && !exp_ack_cur[(m_last + k) % N]) win = (m_last + k) % N;
      if (win >= 0) begin
        e.id   = ID_W'(win);
        e.addr = a[win];
        e.data = d[win];
        sb.push_back(e);
        m_last             = win;
        m_valid            = 1'b1;
        exp_ack_next[win]  = 1'b1;
      end else if (hs) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      begin_cycle();
      end_cycle();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ack", bus.req_in__ack, exp_ack_cur);
      chk("valid", bus.req_out__valid, exp_valid_cur);
      chk("busy", bus.busy, exp_valid_cur);
      if (bus.req_out__valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL payload: output valid with empty scoreboard");
        end else begin
          chk("grant_id", bus.grant_id, sb[0].id);
          chk("address", bus.req_out__address, sb[0].addr);
          chk("data", {bus.req_out__data_3, bus.req_out__data_2, bus.req_out__data_1, bus.req_out__data_0}, sb[0].data);
          if (bus.ack_out) begin
            seen_ids.push_back(int'(bus.grant_id));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int base;
    reset = 1'b1;
    bus.ack_out = 1'b0;
    bus.req_in__valid = '0;
    bus.req_in__address = '0;
    bus.req_in__data_0 = '0;
    bus.req_in__data_1 = '0;
    bus.req_in__data_2 = '0;
    bus.req_in__data_3 = '0;
    v = '0; renew = '0; keep = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    ack_o = 1'b0; rst_i = 1'b1; rand_mode = 1'b0; flush = 1'b0; mon_en = 1'b0;
    m_valid = 1'b0; m_last = N - 1; exp_ack_cur = '0; exp_ack_next = '0; exp_valid_cur = 1'b0;

    // Reset state
    begin_cycle(); mon_en = 1'b1; end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle();
    chk("rst_valid", bus.req_out__valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.req_in__ack, 0);
    chk("rst_grant", bus.grant_id, 0);
    chk("rst_addr", bus.req_out__address, 0);
    chk("rst_data", {bus.req_out__data_3, bus.req_out__data_2, bus.req_out__data_1, bus.req_out__data_0}, 0);
    rst_i = 1'b0;

    // Single request from requester 2
    v[2] = 1'b1; a[2] = 16'h0050; d[2] = {192'h0, 64'h20202087_00000001};
    end_cycle();
    begin_cycle();
    chk("t1_ack", bus.req_in__ack, 4'b0100);
    chk("t1_valid", bus.req_out__valid, 1);
    chk("t1_grant", bus.grant_id, 2);
    chk("t1_addr", bus.req_out__address, 16'h0050);
    chk("t1_data0", bus.req_out__data_0, 64'h20202087_00000001);
    ack_o = 1'b1;
    end_cycle();
    run(4);

    // All four requesting, ack_out held high
    begin_cycle(); rst_i = 1'b1; end_cycle();
    begin_cycle(); rst_i = 1'b0;
    base = seen_ids.size();
    renew = '1;
    for (int i = 0; i < N; i++) new_payload(i);
    ack_o = 1'b1;
    end_cycle();
    run(12);
    renew = '0;
    run(10);
    for (int k = 0; k < 5; k++)
      chk("t2_order", (seen_ids.size() > base + k) ? seen_ids[base + k] : -1, k % N);

    // Requester 1 waits while downstream stalls
    ack_o = 1'b0;
    begin_cycle(); new_payload(0); end_cycle();
    begin_cycle(); new_payload(1); end_cycle();
    run(20);
    begin_cycle();
    chk("t3_busy", bus.busy, 1);
    chk("t3_grant", bus.grant_id, 0);
    chk("t3_no_ack1", bus.req_in__ack[1], 0);
    ack_o = 1'b1;
    end_cycle();
    begin_cycle();
    chk("t3_ack1", bus.req_in__ack[1], PIPE);
    end_cycle();
    run(6);

    // Requester 0 keeps valid one cycle past its ack
    begin_cycle(); rst_i = 1'b1; end_cycle();
    begin_cycle(); rst_i = 1'b0;
    keep[0] = 1'b1; new_payload(0); new_payload(1); ack_o = 1'b1;
    end_cycle();
    begin_cycle(); end_cycle();
    keep[0] = 1'b0;
    begin_cycle();
    chk("t4_ack_c2", bus.req_in__ack, PIPE ? 4'b0010 : 4'b0000);
    end_cycle();
    run(8);

    // Reset while ISSUE is stalled
    ack_o = 1'b0;
    begin_cycle(); new_payload(0); end_cycle();
    run(2);
    begin_cycle(); rst_i = 1'b1; new_payload(3); end_cycle();
    begin_cycle(); rst_i = 1'b0;
    chk("t5_valid", bus.req_out__valid, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_ack", bus.req_in__ack, 0);
    new_payload(0);
    end_cycle();
    begin_cycle();
    chk("t5_first", bus.grant_id, 0);
    ack_o = 1'b1;
    end_cycle();
    run(8);

    // Random traffic
    rand_mode = 1'b1;
    run(10000);
    rand_mode = 1'b0;
    ack_o = 1'b1;
    run(30);
    chk("drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
